// File: rtl/branch_fetch_ctrl.sv
// rtl/branch_fetch_ctrl.sv - fetch PC sequencer with direct-mapped branch predictor and mispredict redirect
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   stall               hazard hold request, freezes pc (a mispredict overrides it)
//   ex_valid            EX stage holds a real instruction
//   ex_is_branch        EX instruction is a conditional branch
//   ex_is_jump          EX instruction is jal/jalr
//   ex_pc               PC of the EX instruction
//   ex_taken            resolved direction from the branch unit
//   ex_target           resolved target from the branch unit (only [PC_W-1:2] used)
//   ex_pred_taken       direction predicted at fetch, carried to EX
//   ex_pred_target      target predicted at fetch, carried to EX
//   pc                  current fetch PC
//   pred_taken          prediction for the current pc
//   pred_target         predicted target for the current pc
//   flush               kill IF/ID and ID/EX this cycle (combinational)
//   mispredict_cnt      number of flush cycles since reset, wraps at 2^16

module branch_fetch_ctrl #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic [PC_W-1:0] pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    output logic            flush,
    output logic [15:0]     mispredict_cnt
);

    localparam int              ENTRIES = 1 << IDX_W;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    // Untagged predictor table: aliasing is tolerated and repaired by the
    // mispredict path.
    logic [1:0]      ctr [ENTRIES];
    logic [PC_W-1:0] tgt [ENTRIES];
    logic [ENTRIES-1:0] v;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic            resolve;
    logic [PC_W-1:0] act_tgt;
    logic            dir_miss;
    logic            tgt_miss;
    logic            alias_miss;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc_next;

    // Bits of the branch-unit target that cannot address the fetch space.
    logic unused_target_bits;
    assign unused_target_bits = ^{ex_target[31:PC_W], ex_target[1:0]};

    assign rd_idx = pc[IDX_W+1:2];
    assign wr_idx = ex_pc[IDX_W+1:2];

    // Prediction reads the registered table only; an update on this edge
    // is seen one cycle later (no bypass).
    always_comb begin
        pred_taken  = v[rd_idx] && (ctr[rd_idx] >= 2'd2);
        pred_target = tgt[rd_idx];
    end

    always_comb begin
        resolve     = ex_valid && (ex_is_branch || ex_is_jump);
        act_tgt     = {ex_target[PC_W-1:2], 2'b00};
        dir_miss    = resolve && (ex_taken != ex_pred_taken);
        tgt_miss    = resolve && ex_taken && ex_pred_taken && (act_tgt != ex_pred_target);
        // A non-control-flow instruction that aliased onto a taken entry.
        alias_miss  = ex_valid && !resolve && ex_pred_taken;
        mispredict  = dir_miss || tgt_miss || alias_miss;
        redirect_pc = (resolve && ex_taken) ? act_tgt : (ex_pc + PC_STEP);
        flush       = mispredict;
    end

    // Mispredict beats stall: the stalled younger instructions are being
    // flushed anyway, so there is nothing left to hold.
    always_comb begin
        pc_next = pc + PC_STEP;
        if (mispredict) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= '0;
            mispredict_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

    // Training happens on every resolving instruction, stalled or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                ctr[k] <= 2'b01;
                tgt[k] <= '0;
            end
            v <= '0;
        end else if (resolve) begin
            if (ex_taken) begin
                if (ctr[wr_idx] != 2'b11) begin
                    ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
                end
                tgt[wr_idx] <= act_tgt;
                v[wr_idx]   <= 1'b1;
            end else if (ctr[wr_idx] != 2'b00) begin
                ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// tb/tb_branch_fetch_ctrl.sv - scoreboard bench for branch_fetch_ctrl against a table-level reference model

module tb_branch_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [8:0]  ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [8:0]  ex_pred_target;
    logic [8:0]  pc;
    logic        pred_taken;
    logic [8:0]  pred_target;
    logic        flush;
    logic [15:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_fetch_ctrl #(.PC_W(9), .IDX_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        int unsigned pc;
        bit          pt;
        int unsigned ptg;
        bit          fl;
        int unsigned cnt;
    } exp_t;

    exp_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 0;

    // Reference model state: plain integers, addresses kept modulo 512.
    int unsigned m_pc;
    int          m_ctr [8];
    bit          m_v   [8];
    int unsigned m_tgt [8];
    int unsigned m_cnt;
    bit          last_flush;

    task automatic model_reset();
        m_pc  = 0;
        m_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            m_ctr[k] = 1;
            m_v[k]   = 0;
            m_tgt[k] = 0;
        end
        last_flush = 0;
    endtask

    function automatic int idx_of(input int unsigned a);
        return (a / 4) % 8;
    endfunction

    function automatic bit model_pt(input int unsigned a);
        return m_v[idx_of(a)] && (m_ctr[idx_of(a)] >= 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // One cycle: drive inputs after the edge, predict this cycle's outputs,
    // then advance the model across the coming edge.
    task automatic step(input bit rst, input bit st, input bit ev, input bit br, input bit jp,
                        input int unsigned epc, input bit tk, input logic [31:0] etg,
                        input bit ptk, input int unsigned ptg);
        exp_t e;
        bit res;
        bit mis;
        int unsigned act;
        int unsigned redir;
        int j;
        @(posedge clk);
        #1;
        reset          = rst;
        stall          = st;
        ex_valid       = ev;
        ex_is_branch   = br;
        ex_is_jump     = jp;
        ex_pc          = 9'(epc);
        ex_taken       = tk;
        ex_target      = etg;
        ex_pred_taken  = ptk;
        ex_pred_target = 9'(ptg);

        res   = ev && (br || jp);
        act   = ((etg % 512) / 4) * 4;
        mis   = (res && (tk != ptk)) ||
                (res && tk && ptk && (act != ptg)) ||
                (ev && !res && ptk);
        redir = (res && tk) ? act : (epc + 4) % 512;

        e.pc  = m_pc;
        e.pt  = model_pt(m_pc);
        e.ptg = m_tgt[idx_of(m_pc)];
        e.fl  = mis;
        e.cnt = m_cnt;
        expq.push_back(e);
        last_flush = mis;

        if (rst) begin
            model_reset();
        end else begin
            if (mis)      m_pc = redir;
            else if (!st) m_pc = e.pt ? e.ptg : (m_pc + 4) % 512;
            if (res) begin
                j = idx_of(epc);
                if (tk) begin
                    if (m_ctr[j] < 3) m_ctr[j]++;
                    m_tgt[j] = act;
                    m_v[j]   = 1;
                end else if (m_ctr[j] > 0) begin
                    m_ctr[j]--;
                end
            end
            if (mis) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic idle(input bit st);
        step(0, st, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    // Steer fetch to addr via an aliased non-branch predicted taken, then
    // spend the required bubble cycle fetching addr.
    task automatic redirect_to(input int unsigned addr);
        step(0, 0, 1, 0, 0, (addr + 508) % 512, 0, 32'h0, 1, 0);
        idle(0);
    endtask

    task automatic resolve_0x10(input bit tk);
        bit pt;
        pt = model_pt(32'h10);
        step(0, 0, 1, 1, 0, 32'h10, tk, 32'h80, pt, m_tgt[idx_of(32'h10)]);
        idle(0);
        redirect_to(32'h10);
        idle(0);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pc",             32'(pc),             32'(e.pc));
                chk("pred_taken",     32'(pred_taken),     32'(e.pt));
                chk("pred_target",    32'(pred_target),    32'(e.ptg));
                chk("flush",          32'(flush),          32'(e.fl));
                chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        bit          st, ev, br, jp, tk, ptk, rst;
        int unsigned epc, ptg, act;
        logic [31:0] etg;

        reset = 1; stall = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
        ex_pc = '0; ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
        @(posedge clk);
        @(posedge clk);
        model_reset();

        // Free-running sequence through the 0x1FC -> 0 wrap.
        for (int k = 0; k < 132; k++) idle(0);

        // Cold taken branch, then observe the learned prediction at 0x010.
        step(0, 0, 1, 1, 0, 32'h10, 1, 32'h40, 0, 0);
        idle(0);
        redirect_to(32'h10);
        idle(0);

        // Stall hold, then stall together with a mispredict.
        redirect_to(32'h20);
        idle(1); idle(1); idle(1);
        step(0, 1, 1, 1, 0, 32'h60, 1, 32'h80, 0, 0);
        idle(0);

        // Aliased non-branch predicted taken.
        step(0, 0, 1, 0, 0, 32'h30, 0, 32'h0, 1, 0);
        idle(0);

        // jalr target mismatch, then observe retrained target.
        step(0, 0, 1, 0, 1, 32'h10, 1, 32'h80, 1, 32'h40);
        idle(0);
        redirect_to(32'h10);
        idle(0);

        // Counter saturation and decay.
        for (int k = 0; k < 4; k++) resolve_0x10(1);
        for (int k = 0; k < 3; k++) resolve_0x10(0);

        // Reset during a stalled mispredict.
        step(1, 1, 1, 1, 0, 32'h44, 1, 32'h100, 0, 0);
        idle(0);
        idle(0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 4) == 0);
            ev  = !last_flush && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin br = 1; jp = 0; end
                6, 7:             begin br = 0; jp = 1; end
                default:          begin br = 0; jp = 0; end
            endcase
            epc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) * 4 : $urandom_range(0, 127) * 4;
            tk  = $urandom_range(0, 1);
            etg = $urandom;
            if ($urandom_range(0, 1) == 1) etg[8:0] = 9'($urandom_range(0, 15) * 4);
            act = ((etg % 512) / 4) * 4;
            ptk = ($urandom_range(0, 3) != 0) ? model_pt(epc) : bit'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       ptg = act;
                1:       ptg = m_tgt[idx_of(epc)];
                default: ptg = $urandom_range(0, 127) * 4;
            endcase
            step(rst, st, ev, br, jp, epc, tk, etg, ptk, ptg);
        end

        @(negedge clk);
        #1;
        done = 1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
